bram_address_generator_2d: RTL and testbench

BRAM_ADDRESS_GENERATOR_2D -- requirements
Module: bram_address_generator_2d

---
 rtl/bram_address_generator_2d.sv | 119 +++++++++++
 tb/tb_bram_address_generator_2d.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bram_address_generator_2d.sv
// bram_address_generator_2d: maps fixed-point box centres to clamped (channel, row, column) BRAM addresses.
// Three-stage valid/ready pipeline: multiply, shift+clamp, address compose.
module bram_address_generator_2d #(
    parameter int          COORD_WIDTH  = 16,
    parameter int          FRAC_BITS    = 8,
    parameter int          RECIP_FRAC   = 16,
    parameter int unsigned X_RECIP      = 2048,
    parameter int unsigned Y_RECIP      = 2048,
    parameter int          GRID_W       = 13,
    parameter int          GRID_H       = 13,
    parameter int          NUM_CHANNELS = 3,
    parameter int          ADDR_WIDTH   = 10,
    parameter int unsigned BASE_ADDR    = 0,
    localparam int         CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COORD_WIDTH-1:0] x_in,
    input  logic [COORD_WIDTH-1:0] y_in,
    input  logic [CH_WIDTH-1:0]    ch_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic [COORD_WIDTH-1:0] x_idx_out,
    output logic [COORD_WIDTH-1:0] y_idx_out,
    output logic                   overflow_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            overflow_count
);
    localparam int PW = COORD_WIDTH + RECIP_FRAC + 1;
    localparam int SH = FRAC_BITS + RECIP_FRAC;
    localparam logic [PW-1:0] XR = PW'(X_RECIP);
    localparam logic [PW-1:0] YR = PW'(Y_RECIP);

    logic                   r1_valid, r2_valid, r3_valid;
    logic [PW-1:0]          r1_px, r1_py;
    logic [CH_WIDTH-1:0]    r1_ch, r2_ch;
    logic [COORD_WIDTH-1:0] r2_ix, r2_iy, r3_ix, r3_iy;
    logic                   r2_ovf, r3_ovf;
    logic [ADDR_WIDTH-1:0]  r3_addr;
    logic [15:0]            r_ovf_cnt;

    logic                   w_s1_load, w_s2_load, w_s3_load;
    logic [PW-1:0]          w_ix_full, w_iy_full;
    logic                   w_x_ovf, w_y_ovf, w_c_ovf;
    logic [COORD_WIDTH-1:0] w_ix, w_iy;
    logic [CH_WIDTH-1:0]    w_ch;
    logic [ADDR_WIDTH-1:0]  w_addr;

    // Each stage loads when empty or when its successor is loading this cycle.
    assign w_s3_load = !r3_valid || out_ready;
    assign w_s2_load = !r2_valid || w_s3_load;
    assign w_s1_load = !r1_valid || w_s2_load;
    assign in_ready  = reset_n && w_s1_load;

    always_comb begin
        w_ix_full = r1_px >> SH;
        w_iy_full = r1_py >> SH;
        w_x_ovf   = w_ix_full >= PW'(GRID_W);
        w_y_ovf   = w_iy_full >= PW'(GRID_H);
        w_c_ovf   = 32'(r1_ch) >= 32'(NUM_CHANNELS);
        w_ix      = w_x_ovf ? COORD_WIDTH'(GRID_W - 1) : w_ix_full[COORD_WIDTH-1:0];
        w_iy      = w_y_ovf ? COORD_WIDTH'(GRID_H - 1) : w_iy_full[COORD_WIDTH-1:0];
        w_ch      = w_c_ovf ? CH_WIDTH'(NUM_CHANNELS - 1) : r1_ch;
    end

    assign w_addr = ADDR_WIDTH'(BASE_ADDR + (32'(r2_ch) * 32'(GRID_H) + 32'(r2_iy)) * 32'(GRID_W) + 32'(r2_ix));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_valid  <= 1'b0;
            r1_px     <= '0;
            r1_py     <= '0;
            r1_ch     <= '0;
            r2_valid  <= 1'b0;
            r2_ix     <= '0;
            r2_iy     <= '0;
            r2_ch     <= '0;
            r2_ovf    <= 1'b0;
            r3_valid  <= 1'b0;
            r3_addr   <= '0;
            r3_ix     <= '0;
            r3_iy     <= '0;
            r3_ovf    <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_s1_load) begin
                r1_valid <= in_valid;
                r1_px    <= PW'(x_in) * XR;
                r1_py    <= PW'(y_in) * YR;
                r1_ch    <= ch_in;
            end
            if (w_s2_load) begin
                r2_valid <= r1_valid;
                r2_ix    <= w_ix;
                r2_iy    <= w_iy;
                r2_ch    <= w_ch;
                r2_ovf   <= w_x_ovf || w_y_ovf || w_c_ovf;
            end
            if (w_s3_load) begin
                r3_valid <= r2_valid;
                r3_addr  <= w_addr;
                r3_ix    <= r2_ix;
                r3_iy    <= r2_iy;
                r3_ovf   <= r2_ovf;
            end
            if (r3_valid && out_ready && r3_ovf && r_ovf_cnt != 16'hFFFF)
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign out_valid      = r3_valid;
    assign addr_out       = r3_addr;
    assign x_idx_out      = r3_ix;
    assign y_idx_out      = r3_iy;
    assign overflow_out   = r3_ovf;
    assign overflow_count = r_ovf_cnt;
endmodule

// File: tb/tb_bram_address_generator_2d.sv
// tb_bram_address_generator_2d: directed vectors on a default 13x13 instance and a 4x4 instance
// (same stimulus) so the cell-index clamp boundary is reachable, plus stall, reset and saturation sequences.
module tb_bram_address_generator_2d;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] x_in, y_in;
    logic [1:0]  ch_in;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid, overflow_out;
    logic [9:0]  addr_out;
    logic [15:0] x_idx_out, y_idx_out, overflow_count;
    logic        b_in_ready, b_out_valid, b_overflow_out;
    logic [9:0]  b_addr_out;
    logic [15:0] b_x_idx_out, b_y_idx_out, b_overflow_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bram_address_generator_2d dut (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .y_in(y_in), .ch_in(ch_in),
        .in_valid(in_valid), .in_ready(in_ready), .addr_out(addr_out),
        .x_idx_out(x_idx_out), .y_idx_out(y_idx_out), .overflow_out(overflow_out),
        .out_valid(out_valid), .out_ready(out_ready), .overflow_count(overflow_count)
    );

    bram_address_generator_2d #(.GRID_W(4), .GRID_H(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .x_in(x_in), .y_in(y_in), .ch_in(ch_in),
        .in_valid(in_valid), .in_ready(b_in_ready), .addr_out(b_addr_out),
        .x_idx_out(b_x_idx_out), .y_idx_out(b_y_idx_out), .overflow_out(b_overflow_out),
        .out_valid(b_out_valid), .out_ready(out_ready), .overflow_count(b_overflow_count)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  ch;
        int a_addr, a_xi, a_yi, a_ovf;
        int b_addr, b_xi, b_yi, b_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        logic       pst, blocked;
        logic [9:0] pa;
        logic [15:0] pxi, pyi;
        logic       povf;
        int sent, got;
        // cell index = coordinate >> 13 for the default 32-unit cells
        vecs[0] = '{16'h6400, 16'hC800, 2'd1, 250, 3, 6, 0,  31, 3, 3, 1};
        vecs[1] = '{16'hFFFF, 16'h0000, 2'd0,   7, 7, 0, 0,   3, 3, 0, 1};
        vecs[2] = '{16'h0000, 16'h0000, 2'd3, 338, 0, 0, 1,  32, 0, 0, 1};
        vecs[3] = '{16'h8000, 16'h7FFF, 2'd2, 381, 4, 3, 0,  47, 3, 3, 1};
        vecs[4] = '{16'h7FFF, 16'h8000, 2'd0,  55, 3, 4, 0,  15, 3, 3, 1};
        vecs[5] = '{16'h1FFF, 16'h2000, 2'd2, 351, 0, 1, 0,  36, 0, 1, 0};
        vecs[6] = '{16'hE000, 16'hE000, 2'd1, 267, 7, 7, 0,  31, 3, 3, 1};
        vecs[7] = '{16'h0000, 16'h0000, 2'd0,   0, 0, 0, 0,   0, 0, 0, 0};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x_in = '0; y_in = '0; ch_in = '0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst count", 32'(overflow_count), 0);
        chk("rst addr", 32'(addr_out), 0);
        reset_n = 1'b1;
        #1 chk("post-rst in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            x_in = vecs[i].x; y_in = vecs[i].y; ch_in = vecs[i].ch; in_valid = 1'b1;
            #1 chk("vec in_ready", 32'(in_ready), 1);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk("vec early valid", 32'(out_valid), 0);
            @(negedge clk);
            chk("vec out_valid", 32'(out_valid), 1);
            chk("vec addr", 32'(addr_out), vecs[i].a_addr);
            chk("vec x_idx", 32'(x_idx_out), vecs[i].a_xi);
            chk("vec y_idx", 32'(y_idx_out), vecs[i].a_yi);
            chk("vec ovf", 32'(overflow_out), vecs[i].a_ovf);
            chk("vec b addr", 32'(b_addr_out), vecs[i].b_addr);
            chk("vec b x_idx", 32'(b_x_idx_out), vecs[i].b_xi);
            chk("vec b y_idx", 32'(b_y_idx_out), vecs[i].b_yi);
            chk("vec b ovf", 32'(b_overflow_out), vecs[i].b_ovf);
        end
        @(negedge clk);
        chk("count after table", 32'(overflow_count), 1);
        chk("b count after table", 32'(b_overflow_count), 6);

        // 10 back-to-back inputs with a 4-cycle output stall
        sent = 0; got = 0; pst = 1'b0; blocked = 1'b0;
        pa = '0; pxi = '0; pyi = '0; povf = 1'b0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            out_ready = !(c >= 5 && c <= 8);
            in_valid = sent < 10;
            x_in = 16'((sent % 4) << 13); y_in = 16'((sent / 4) << 13); ch_in = 2'd0;
            #1;
            if (pst) begin
                chk("stall valid", 32'(out_valid), 1);
                chk("stall addr", 32'(addr_out), 32'(pa));
                chk("stall x_idx", 32'(x_idx_out), 32'(pxi));
                chk("stall y_idx", 32'(y_idx_out), 32'(pyi));
                chk("stall ovf", 32'(overflow_out), 32'(povf));
            end
            if (out_valid && out_ready) begin
                chk("stream order", 32'(addr_out), (got / 4) * 13 + got % 4);
                got++;
            end
            pst = out_valid && !out_ready;
            pa = addr_out; pxi = x_idx_out; pyi = y_idx_out; povf = overflow_out;
            if (in_valid && in_ready) sent++;
            else if (in_valid) blocked = 1'b1;
        end
        chk("stream all received", got, 10);
        chk("stream in_ready dropped", 32'(blocked), 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;

        // reset with results in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; x_in = 16'h4000; y_in = 16'h2000; ch_in = 2'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("pre-reset out_valid", 32'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 32'(out_valid), 0);
        chk("mid-rst count", 32'(overflow_count), 0);
        chk("mid-rst in_ready", 32'(in_ready), 0);
        chk("mid-rst addr", 32'(addr_out), 0);
        chk("mid-rst x_idx", 32'(x_idx_out), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        #1 chk("release in_ready", 32'(in_ready), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no stale output", 32'(out_valid), 0);
        end

        // overflow counter saturation
        x_in = '0; y_in = '0; ch_in = 2'd3;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("count at 65535", 32'(overflow_count), 32'hFFFF);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("count saturated", 32'(overflow_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
